// File: rtl/clock_meter_pkg.sv
// rtl/clock_meter_pkg.sv - shared FSM encodings and default sizes for the clock period meter
package clock_meter_pkg;

    localparam int CNT_W_DEFAULT       = 16;
    localparam int SYNC_STAGES_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        MEASURE = 2'd2
    } meter_state_t;

    // Width-safe constant one for a counter of width w (w <= 32).
    function automatic logic [31:0] count_one();
        return 32'd1;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchronizer with history flop and rise/fall strobes
module sync_edge_detect
    import clock_meter_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic Clk,
    input  logic Rst,
    input  logic sig_in,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist;

    // Shift the asynchronous input through the synchronizer chain, then remember the last synchronized value.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync_q <= '0;
            hist   <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], sig_in};
            hist   <= sync_q[STAGES-1];
        end
    end

    assign sync = sync_q[STAGES-1];
    assign rise = sync & ~hist;
    assign fall = ~sync & hist;

endmodule

// File: rtl/clock_period_meter.sv
// rtl/clock_period_meter.sv - measures period (and high time when CLOCK_METER_DUTY_EN is defined) of a slow input in Clk cycles
module clock_period_meter
    import clock_meter_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             enable,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(count_one());

    meter_state_t     state;
    meter_state_t     state_nxt;
    logic             sync;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    logic             cnt_max;
    logic             start_meas;
    logic             report;
    logic             expire;
    logic             hold_zero;
    logic             meas_active;

    sync_edge_detect #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .Clk    (Clk),
        .Rst    (Rst),
        .sig_in (sig_in),
        .sync   (sync),
        .rise   (rise),
        .fall   (fall)
    );

    assign cnt_max     = &cnt;
    assign hold_zero   = !enable || (state == IDLE);
    assign meas_active = enable && (state == MEASURE);

    // State register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-cycle control strobes; a rise always beats an expiring counter.
    always_comb begin
        state_nxt  = state;
        start_meas = 1'b0;
        report     = 1'b0;
        expire     = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = ARMED;
                end
                ARMED: begin
                    if (rise) begin
                        state_nxt  = MEASURE;
                        start_meas = 1'b1;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        report = 1'b1;
                    end else if (cnt_max) begin
                        expire    = 1'b1;
                        state_nxt = ARMED;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Period counter and the registered period/valid/timeout outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt     <= '0;
            period  <= '0;
            valid   <= 1'b0;
            timeout <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (hold_zero) begin
                cnt <= '0;
            end else if (start_meas) begin
                cnt <= ONE;
            end else if (report) begin
                period  <= cnt;
                valid   <= 1'b1;
                timeout <= 1'b0;
                cnt     <= ONE;
            end else if (expire) begin
                timeout <= 1'b1;
                cnt     <= '0;
            end else if (meas_active) begin
                cnt <= cnt + ONE;
            end
        end
    end

`ifdef CLOCK_METER_DUTY_EN
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] hlatch;

    // High-phase counter; its value is captured on each fall and published on the following rise.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            hcnt      <= '0;
            hlatch    <= '0;
            high_time <= '0;
        end else begin
            if (hold_zero) begin
                hcnt <= '0;
            end else if (start_meas || report) begin
                hcnt <= ONE;
            end else if (expire) begin
                hcnt <= '0;
            end else if (meas_active && sync) begin
                hcnt <= hcnt + ONE;
            end
            if (meas_active && fall) begin
                hlatch <= hcnt;
            end
            if (report) begin
                high_time <= hlatch;
            end
        end
    end
`else
    logic duty_unused;

    assign duty_unused = sync ^ fall;
    assign high_time   = '0;
`endif

endmodule

// File: tb/tb_clock_period_meter.sv
// tb/tb_clock_period_meter.sv - directed, table-driven self-checking bench for clock_period_meter
module tb_clock_period_meter;

    localparam int CW   = 14;
    localparam int MAXV = (1 << CW) - 1;

    logic          Clk = 1'b0;
    logic          Rst = 1'b1;
    logic          enable = 1'b0;
    logic          sig_in = 1'b0;
    logic [CW-1:0] period;
    logic [CW-1:0] high_time;
    logic          valid;
    logic          timeout;

    clock_period_meter #(
        .CNT_W       (CW),
        .SYNC_STAGES (2)
    ) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .enable    (enable),
        .sig_in    (sig_in),
        .period    (period),
        .high_time (high_time),
        .valid     (valid),
        .timeout   (timeout)
    );

    always #5 Clk = ~Clk;

    logic [CW-1:0] vq_p[$];
    logic [CW-1:0] vq_h[$];

    // Record every valid pulse with the values it published.
    always @(negedge Clk) begin
        if (valid) begin
            vq_p.push_back(period);
            vq_h.push_back(high_time);
        end
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        tick(2);
        Rst = 1'b0;
    endtask

    task automatic drive_wave(input int lo, input int hi, input int n);
        for (int k = 0; k < n; k++) begin
            sig_in = 1'b1;
            tick(hi);
            sig_in = 1'b0;
            tick(lo);
        end
    endtask

    function automatic int exp_high(input int h);
`ifdef CLOCK_METER_DUTY_EN
        return h;
`else
        return 0;
`endif
    endfunction

    task automatic check_valids(input string name, input int base, input int cnt,
                                input int ep, input int eh);
        check({name, "_count"}, vq_p.size() - base, cnt);
        for (int i = base; i < vq_p.size() && i < base + cnt; i++) begin
            check({name, "_period"}, vq_p[i], ep);
            check({name, "_high"}, vq_h[i], eh);
        end
    endtask

    typedef struct {
        int lo;
        int hi;
        int n;
        int exp_period;
        int exp_high;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int base;

        vecs[0] = '{lo: 600,  hi: 600,  n: 3, exp_period: 1200, exp_high: exp_high(600)};
        vecs[1] = '{lo: 4096, hi: 4096, n: 2, exp_period: 8192, exp_high: exp_high(4096)};
        vecs[2] = '{lo: 5,    hi: 3,    n: 6, exp_period: 8,    exp_high: exp_high(3)};
        vecs[3] = '{lo: 1,    hi: 1,    n: 6, exp_period: 2,    exp_high: exp_high(1)};
        vecs[4] = '{lo: 7,    hi: 2,    n: 4, exp_period: 9,    exp_high: exp_high(2)};

        do_reset();
        tick(1);
        check("reset_period", period, 0);
        check("reset_high", high_time, 0);
        check("reset_valid", valid, 0);
        check("reset_timeout", timeout, 0);
        check("reset_state", int'(dut.state), 0);

        // Disabled: edges must be ignored entirely.
        base = vq_p.size();
        drive_wave(5, 3, 3);
        tick(5);
        check("disabled_count", vq_p.size() - base, 0);

        for (int v = 0; v < 5; v++) begin
            do_reset();
            enable = 1'b1;
            sig_in = 1'b0;
            tick(5);
            base = vq_p.size();
            drive_wave(vecs[v].lo, vecs[v].hi, vecs[v].n);
            tick(10);
            check_valids($sformatf("vec%0d", v), base, vecs[v].n - 1,
                         vecs[v].exp_period, vecs[v].exp_high);
            check($sformatf("vec%0d_timeout", v), timeout, 0);
        end

        // Rise coinciding with an all-ones counter, then a true timeout and recovery.
        do_reset();
        enable = 1'b1;
        tick(5);
        base = vq_p.size();
        sig_in = 1'b1;
        tick(5);
        sig_in = 1'b0;
        tick(MAXV - 5);
        sig_in = 1'b1;
        tick(5);
        sig_in = 1'b0;
        tick(10);
        check_valids("boundary", base, 1, MAXV, exp_high(5));
        check("boundary_timeout", timeout, 0);
        tick(16300 - 15);
        check("pre_timeout", timeout, 0);
        tick(120);
        check("timeout_set", timeout, 1);
        check("timeout_state", int'(dut.state), 1);
        check("timeout_period_held", period, MAXV);
        check("timeout_no_valid", vq_p.size() - base, 1);
        base = vq_p.size();
        drive_wave(600, 600, 1);
        check("rearm_timeout_held", timeout, 1);
        check("rearm_no_valid", vq_p.size() - base, 0);
        drive_wave(600, 600, 2);
        tick(10);
        check_valids("recover", base, 2, 1200, exp_high(600));
        check("recover_timeout", timeout, 0);

        // Enable dropped mid-period.
        do_reset();
        enable = 1'b1;
        tick(5);
        base = vq_p.size();
        drive_wave(600, 600, 2);
        check_valids("pre_drop", base, 1, 1200, exp_high(600));
        base = vq_p.size();
        enable = 1'b0;
        tick(100);
        sig_in = 1'b1;
        tick(100);
        sig_in = 1'b0;
        tick(100);
        check("drop_no_valid", vq_p.size() - base, 0);
        check("drop_period_held", period, 1200);
        check("drop_state", int'(dut.state), 0);
        enable = 1'b1;
        drive_wave(400, 400, 3);
        tick(10);
        check_valids("post_drop", base, 2, 800, exp_high(400));

        // Reset while measuring.
        do_reset();
        enable = 1'b1;
        tick(5);
        drive_wave(600, 600, 2);
        check("pre_rst_period", period, 1200);
        Rst = 1'b1;
        tick(1);
        Rst = 1'b0;
        check("rst_period", period, 0);
        check("rst_high", high_time, 0);
        check("rst_valid", valid, 0);
        check("rst_timeout", timeout, 0);
        base = vq_p.size();
        tick(5);
        drive_wave(500, 500, 1);
        check("rst_first_rise_no_valid", vq_p.size() - base, 0);
        drive_wave(500, 500, 2);
        tick(10);
        check_valids("post_rst", base, 2, 1000, exp_high(500));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
